// File: rtl/iigs_top_pkg.sv
// iigs_top_pkg: shared types and constants for the IIgs display/boot-sector shell.
//   - seq_state_e : boot-sector sequencer states
//   - raster timing constants for a 640x480 frame (800x525 total)
//   - cell geometry: 32x16 cells of 16x16 pixels covering x<512, y<256
//   - rgb332_expand(): byte to 24-bit colour
// Optional feature macro used by the top: HDD_WRITEBACK_EN.
package iigs_top_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StWb,
      StDone
   } seq_state_e;

   // Horizontal timing in pixel steps
   localparam logic [9:0] HActive    = 10'd640;
   localparam logic [9:0] HSyncStart = 10'd656;  // active + front porch
   localparam logic [9:0] HSyncEnd   = 10'd752;  // sync start + 96
   localparam logic [9:0] HLast      = 10'd799;

   // Vertical timing in lines
   localparam logic [9:0] VActive    = 10'd480;
   localparam logic [9:0] VSyncStart = 10'd490;
   localparam logic [9:0] VSyncEnd   = 10'd492;
   localparam logic [9:0] VLast      = 10'd524;

   // Cell region and sector buffer geometry
   localparam logic [9:0] CellRegionW = 10'd512;
   localparam logic [9:0] CellRegionH = 10'd256;
   localparam logic [8:0] BufLastAddr = 9'd511;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Replicate the short RGB332 fields so full-scale codes map to 0xFF
   function automatic rgb_t rgb332_expand(input logic [7:0] b);
      rgb_t c;
      c.r = {b[7:5], b[7:5], b[7:6]};
      c.g = {b[4:2], b[4:2], b[4:3]};
      c.b = {b[1:0], b[1:0], b[1:0], b[1:0]};
      return c;
   endfunction

endpackage

// File: rtl/iigs_top_sector_ram.sv
// iigs_top_sector_ram: 512x8 dual-port sector buffer.
//   i_clk, i_rst_n        : clock, async active-low reset (read registers only)
//   i_a_we/addr/wdata     : port A host write
//   o_a_rdata             : port A registered read of i_a_addr (read-before-write)
//   i_b_en, i_b_addr      : port B video read enable/address
//   o_b_rdata             : port B registered read data
// Array contents are not reset.
module iigs_top_sector_ram
   import iigs_top_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_a_we,
   input  logic [8:0] i_a_addr,
   input  logic [7:0] i_a_wdata,
   output logic [7:0] o_a_rdata,
   input  logic       i_b_en,
   input  logic [8:0] i_b_addr,
   output logic [7:0] o_b_rdata
);

   logic [7:0] r_mem [512];
   logic [7:0] r_a_rdata;
   logic [7:0] r_b_rdata;

   always_ff @(posedge i_clk) begin
      if (i_a_we) begin
         r_mem[i_a_addr] <= i_a_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a_rdata <= 8'h00;
      end else begin
         r_a_rdata <= r_mem[i_a_addr];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_b_rdata <= 8'h00;
      end else if (i_b_en) begin
         r_b_rdata <= r_mem[i_b_addr];
      end
   end

   assign o_a_rdata = r_a_rdata;
   assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/iigs_top.sv
// iigs_top: IIgs simulation-target display/boot-sector shell.
// Loads one boot sector from the host block device into a 512-byte buffer and shows it as a
// 32x16 grid of RGB332 cells on a 640x480 raster.
//   clk_sys, reset           : system clock, async active-low reset
//   ce_pix                   : pixel step enable
//   R/G/B, HBlank/VBlank     : pixel colour, active-high blanking
//   HS/VS                    : active-low syncs
//   HDD_SECTOR/READ/WRITE    : sector request and one-cycle request pulses
//   HDD_MOUNTED/PROTECT      : image present / read-only
//   HDD_RAM_ADDR/DI/DO/WE    : host access to the sector buffer
// Build option: define HDD_WRITEBACK_EN to write the buffer back to WB_SECTOR after loading.
module iigs_top
   import iigs_top_pkg::*;
#(
   parameter logic [15:0] LOAD_SECTOR = 16'd0,
   parameter logic [15:0] WB_SECTOR   = 16'd1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_pix,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        HBlank,
   output logic        VBlank,
   output logic        HS,
   output logic        VS,
   output logic [15:0] HDD_SECTOR,
   output logic        HDD_READ,
   output logic        HDD_WRITE,
   input  logic        HDD_MOUNTED,
   input  logic        HDD_PROTECT,
   input  logic [8:0]  HDD_RAM_ADDR,
   input  logic [7:0]  HDD_RAM_DI,
   output logic [7:0]  HDD_RAM_DO,
   input  logic        HDD_RAM_WE
);

   // ---------------- Boot-sector sequencer ----------------
   seq_state_e  r_state;
   seq_state_e  w_state_next;
   logic        r_valid;
   logic [15:0] r_sector;
   logic        w_last_write;

   assign w_last_write = HDD_RAM_WE && (HDD_RAM_ADDR == BufLastAddr);

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (HDD_MOUNTED) w_state_next = StReq;
         StReq:  w_state_next = StWait;
         StWait: begin
            if (w_last_write) begin
`ifdef HDD_WRITEBACK_EN
               w_state_next = StWb;
`else
               w_state_next = StDone;
`endif
            end
         end
         StWb:    w_state_next = StDone;
         StDone:  w_state_next = StDone;
         default: w_state_next = StIdle;
      endcase
      // Unmount overrides everything, including a same-cycle final write
      if (!HDD_MOUNTED) w_state_next = StIdle;
   end

   always_comb begin
      HDD_READ  = 1'b0;
      HDD_WRITE = 1'b0;
      if (HDD_MOUNTED) begin
         HDD_READ  = (r_state == StReq);
         HDD_WRITE = (r_state == StWb) && !HDD_PROTECT;
      end
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_valid  <= 1'b0;
         r_sector <= 16'd0;
      end else begin
         if (!HDD_MOUNTED) begin
            r_valid <= 1'b0;
         end else if (r_state == StWait && w_last_write) begin
            r_valid <= 1'b1;
         end
         // Sector is updated on entry so it is stable for the whole request pulse
         if (r_state == StIdle && HDD_MOUNTED) begin
            r_sector <= LOAD_SECTOR;
         end else if (r_state == StWait && w_state_next == StWb && !HDD_PROTECT) begin
            r_sector <= WB_SECTOR;
         end
      end
   end

   assign HDD_SECTOR = r_sector;

   // ---------------- Raster counters ----------------
   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_hcnt <= 10'd0;
         r_vcnt <= 10'd0;
      end else if (ce_pix) begin
         if (r_hcnt == HLast) begin
            r_hcnt <= 10'd0;
            r_vcnt <= (r_vcnt == VLast) ? 10'd0 : r_vcnt + 10'd1;
         end else begin
            r_hcnt <= r_hcnt + 10'd1;
         end
      end
   end

   // ---------------- Pixel pipeline: address -> RAM read -> output ----------------
   logic       w_hblank;
   logic       w_vblank;
   logic       w_show;
   logic [8:0] w_vid_addr;
   logic [7:0] w_vid_data;

   assign w_hblank   = (r_hcnt >= HActive);
   assign w_vblank   = (r_vcnt >= VActive);
   assign w_show     = r_valid && (r_hcnt < CellRegionW) && (r_vcnt < CellRegionH)
                       && !w_hblank && !w_vblank;
   assign w_vid_addr = {r_vcnt[7:4], r_hcnt[8:4]};

   logic r_s1_show, r_s1_hblank, r_s1_vblank, r_s1_hs, r_s1_vs;
   rgb_t r_rgb;
   logic r_hblank, r_vblank, r_hs, r_vs;

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_s1_show   <= 1'b0;
         r_s1_hblank <= 1'b1;
         r_s1_vblank <= 1'b1;
         r_s1_hs     <= 1'b1;
         r_s1_vs     <= 1'b1;
         r_rgb       <= '0;
         r_hblank    <= 1'b1;
         r_vblank    <= 1'b1;
         r_hs        <= 1'b1;
         r_vs        <= 1'b1;
      end else if (ce_pix) begin
         r_s1_show   <= w_show;
         r_s1_hblank <= w_hblank;
         r_s1_vblank <= w_vblank;
         r_s1_hs     <= !((r_hcnt >= HSyncStart) && (r_hcnt < HSyncEnd));
         r_s1_vs     <= !((r_vcnt >= VSyncStart) && (r_vcnt < VSyncEnd));
         r_rgb       <= r_s1_show ? rgb332_expand(w_vid_data) : '0;
         r_hblank    <= r_s1_hblank;
         r_vblank    <= r_s1_vblank;
         r_hs        <= r_s1_hs;
         r_vs        <= r_s1_vs;
      end
   end

   assign R      = r_rgb.r;
   assign G      = r_rgb.g;
   assign B      = r_rgb.b;
   assign HBlank = r_hblank;
   assign VBlank = r_vblank;
   assign HS     = r_hs;
   assign VS     = r_vs;

   iigs_top_sector_ram u_sector_ram (
      .i_clk     (clk_sys),
      .i_rst_n   (reset),
      .i_a_we    (HDD_RAM_WE),
      .i_a_addr  (HDD_RAM_ADDR),
      .i_a_wdata (HDD_RAM_DI),
      .o_a_rdata (HDD_RAM_DO),
      .i_b_en    (ce_pix),
      .i_b_addr  (w_vid_addr),
      .o_b_rdata (w_vid_data)
   );

endmodule

// File: tb/tb_iigs_top.sv
// tb_iigs_top: directed bench for iigs_top with a scoreboard for pixels and host read-back.
module tb_iigs_top;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_pix;
   logic [7:0]  R, G, B;
   logic        HBlank, VBlank, HS, VS;
   logic [15:0] HDD_SECTOR;
   logic        HDD_READ, HDD_WRITE;
   logic        HDD_MOUNTED, HDD_PROTECT;
   logic [8:0]  HDD_RAM_ADDR;
   logic [7:0]  HDD_RAM_DI;
   logic [7:0]  HDD_RAM_DO;
   logic        HDD_RAM_WE;

   always #5 clk_sys = ~clk_sys;

   iigs_top dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_pix       (ce_pix),
      .R            (R),
      .G            (G),
      .B            (B),
      .HBlank       (HBlank),
      .VBlank       (VBlank),
      .HS           (HS),
      .VS           (VS),
      .HDD_SECTOR   (HDD_SECTOR),
      .HDD_READ     (HDD_READ),
      .HDD_WRITE    (HDD_WRITE),
      .HDD_MOUNTED  (HDD_MOUNTED),
      .HDD_PROTECT  (HDD_PROTECT),
      .HDD_RAM_ADDR (HDD_RAM_ADDR),
      .HDD_RAM_DI   (HDD_RAM_DI),
      .HDD_RAM_DO   (HDD_RAM_DO),
      .HDD_RAM_WE   (HDD_RAM_WE)
   );

`ifdef HDD_WRITEBACK_EN
   localparam int ExpWrPulses = 1;
   localparam int ExpWrSector = 1;
`else
   localparam int ExpWrPulses = 0;
   localparam int ExpWrSector = 0;
`endif

   typedef struct {
      int         h;
      int         v;
      logic       vis;
      logic [27:0] e;
   } pix_t;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] m_mem [512];
   logic       m_valid;
   int         m_h, m_v;
   pix_t       pix_q [$];
   logic [7:0] do_q [$];
   int         hs_low, hb_high, rd_pulses, wr_pulses;
   logic [15:0] wr_sec;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Expected {R,G,B,HBlank,VBlank,HS,VS} for raster position (h,v)
   function automatic logic [27:0] exp_pix(input int h, input int v);
      logic [7:0]  b;
      logic [23:0] rgb;
      logic [8:0]  a;
      logic        hb, vb, hs, vs;
      rgb = '0;
      if (m_valid && h < 512 && v < 256) begin
         a   = 9'(((v / 16) * 32) + (h / 16));
         b   = m_mem[a];
         rgb = {b[7:5], b[7:5], b[7:6], b[4:2], b[4:2], b[4:3], b[1:0], b[1:0], b[1:0], b[1:0]};
      end
      hb = (h >= 640) ? 1'b1 : 1'b0;
      vb = (v >= 480) ? 1'b1 : 1'b0;
      hs = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
      vs = (v >= 490 && v < 492) ? 1'b0 : 1'b1;
      return {rgb, hb, vb, hs, vs};
   endfunction

   task automatic run_pix(input int n);
      pix_t p;
      ce_pix = 1'b1;
      for (int i = 0; i < n; i++) begin
         p.h   = m_h;
         p.v   = m_v;
         p.vis = m_valid;
         p.e   = exp_pix(m_h, m_v);
         pix_q.push_back(p);
         if (m_h == 799) begin
            m_h = 0;
            m_v = (m_v == 524) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
         tick();
         if (pix_q.size() == 2) begin
            p = pix_q.pop_front();
            check("pixel", {4'h0, R, G, B, HBlank, VBlank, HS, VS}, {4'h0, p.e});
            if (p.vis && p.h < 16 && p.v < 16 && m_mem[0] == 8'hE0)
               check("cell00_red", {8'h0, R, G, B}, 32'h00FF0000);
            if (!HS) hs_low++;
            if (HBlank) hb_high++;
         end
      end
      ce_pix = 1'b0;
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      HDD_RAM_WE   = 1'b1;
      HDD_RAM_ADDR = a;
      HDD_RAM_DI   = d;
      m_mem[a]     = d;
      tick();
      HDD_RAM_WE   = 1'b0;
   endtask

   task automatic rd(input logic [8:0] a);
      HDD_RAM_ADDR = a;
      do_q.push_back(m_mem[a]);
      tick();
      check("ram_do", {24'h0, HDD_RAM_DO}, {24'h0, do_q.pop_front()});
   endtask

   task automatic count_wr(input int n);
      wr_pulses = 0;
      wr_sec    = 16'h0;
      for (int i = 0; i < n; i++) begin
         if (HDD_WRITE) begin
            wr_pulses++;
            wr_sec = HDD_SECTOR;
         end
         tick();
      end
   endtask

   initial begin
      reset        = 1'b0;
      ce_pix       = 1'b0;
      HDD_MOUNTED  = 1'b0;
      HDD_PROTECT  = 1'b0;
      HDD_RAM_ADDR = 9'd0;
      HDD_RAM_DI   = 8'd0;
      HDD_RAM_WE   = 1'b0;
      m_valid      = 1'b0;
      m_h          = 0;
      m_v          = 0;
      repeat (3) tick();

      // Reset values
      check("rst_rgb", {8'h0, R, G, B}, 32'h0);
      check("rst_blank", {30'h0, HBlank, VBlank}, 32'h3);
      check("rst_sync", {30'h0, HS, VS}, 32'h3);
      check("rst_sector", {16'h0, HDD_SECTOR}, 32'h0);
      check("rst_req", {30'h0, HDD_READ, HDD_WRITE}, 32'h0);
      check("rst_ram_do", {24'h0, HDD_RAM_DO}, 32'h0);

      reset = 1'b1;
      rd_pulses = 0;
      repeat (8) begin
         tick();
         if (HDD_READ) rd_pulses++;
      end
      check("no_read_unmounted", rd_pulses, 0);

      // One full line with nothing loaded: black, sync/blank widths
      hs_low = 0;
      hb_high = 0;
      run_pix(801);
      check("hs_low_per_line", hs_low, 96);
      check("hblank_per_line", hb_high, 160);

      // Mount: single read pulse for LOAD_SECTOR
      HDD_MOUNTED = 1'b1;
      tick();
      check("read_pulse", {31'h0, HDD_READ}, 32'h1);
      check("read_sector", {16'h0, HDD_SECTOR}, 32'h0);
      rd_pulses = 0;
      repeat (4) begin
         tick();
         if (HDD_READ) rd_pulses++;
      end
      check("read_single", rd_pulses, 0);

      // Host fills row 0 of the buffer
      wr(9'd0, 8'hE0);
      for (int i = 1; i < 32; i++) wr(9'(i), 8'($urandom_range(1, 255)));
      run_pix(200);  // still black: final byte not written yet
      for (int i = 0; i < 4; i++) rd(9'(i));
      wr(9'd5, 8'h5A);
      rd(9'd5);

      // Final byte completes the load
      wr(9'd511, 8'hFF);
      m_valid = 1'b1;
      count_wr(4);
      check("wb_pulses", wr_pulses, ExpWrPulses);
      check("wb_sector", {16'h0, wr_sec}, ExpWrSector);
      rd(9'd511);
      run_pix(800);

      // Unmount: display goes black, buffer still readable
      HDD_MOUNTED = 1'b0;
      tick();
      m_valid = 1'b0;
      run_pix(300);
      rd(9'd0);

      // Remount read-only: new read pulse, never a write pulse
      HDD_PROTECT = 1'b1;
      HDD_MOUNTED = 1'b1;
      tick();
      check("remount_read", {31'h0, HDD_READ}, 32'h1);
      tick();
      wr(9'd0, 8'h1C);
      wr(9'd511, 8'h03);
      m_valid = 1'b1;
      count_wr(4);
      check("protect_no_write", wr_pulses, 0);
      run_pix(100);

      // Final write coinciding with unmount: unmount wins
      HDD_MOUNTED = 1'b0;
      tick();
      m_valid = 1'b0;
      HDD_MOUNTED = 1'b1;
      tick();
      check("drop_test_read", {31'h0, HDD_READ}, 32'h1);
      tick();
      HDD_RAM_WE   = 1'b1;
      HDD_RAM_ADDR = 9'd511;
      HDD_RAM_DI   = 8'h77;
      m_mem[511]   = 8'h77;
      HDD_MOUNTED  = 1'b0;
      tick();
      HDD_RAM_WE   = 1'b0;
      run_pix(300);
      HDD_MOUNTED = 1'b1;
      tick();
      check("drop_wins_reload", {31'h0, HDD_READ}, 32'h1);
      tick();

      // Asynchronous reset mid-transfer, then reload on the still-present mount
      #2 reset = 1'b0;
      #1;
      check("midrst_blank", {30'h0, HBlank, VBlank}, 32'h3);
      check("midrst_rgb", {8'h0, R, G, B}, 32'h0);
      check("midrst_read", {31'h0, HDD_READ}, 32'h0);
      tick();
      reset = 1'b1;
      pix_q.delete();
      m_h = 0;
      m_v = 0;
      m_valid = 1'b0;
      tick();
      check("midrst_reload", {31'h0, HDD_READ}, 32'h1);
      run_pix(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
